// File: rtl/sound_pkg.sv
// Shared types, cue table and priority helpers for the sound sequencer.
package sound_pkg;

  typedef enum logic [1:0] {
    UI_PRESS    = 2'd0,
    NEXTLEVEL   = 2'd1,
    CRASH       = 2'd2,
    CELEBRATION = 2'd3
  } sound_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } seq_state_t;

  localparam int CODE_W    = 8;
  localparam int DUR_W     = 8;
  localparam int MAX_NOTES = 4;
  localparam int IDX_W     = 2;

  // Silence between consecutive notes of one cue, in ticks.
  localparam logic [DUR_W-1:0] GAP_TICKS = 8'd10;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [DUR_W-1:0]  dur;   // ticks
  } note_t;

  // Flattened cue table indexed by {sound, note index}; unused slots are zero.
  localparam note_t CUE_NOTES [4*MAX_NOTES] = '{
    // UI_PRESS
    '{8'h30, 8'd40},  '{8'h00, 8'd0},   '{8'h00, 8'd0},   '{8'h00, 8'd0},
    // NEXTLEVEL
    '{8'h28, 8'd60},  '{8'h30, 8'd60},  '{8'h38, 8'd60},  '{8'h00, 8'd0},
    // CRASH
    '{8'h50, 8'd150}, '{8'h60, 8'd150}, '{8'h00, 8'd0},   '{8'h00, 8'd0},
    // CELEBRATION
    '{8'h30, 8'd100}, '{8'h38, 8'd100}, '{8'h40, 8'd100}, '{8'h48, 8'd100}
  };

  // Index of the final note of each cue, indexed by sound.
  localparam logic [IDX_W-1:0] CUE_LAST [4] = '{2'd0, 2'd2, 2'd1, 2'd3};

  // Higher rank wins: CRASH > CELEBRATION > NEXTLEVEL > UI_PRESS.
  function automatic logic [1:0] prio_rank(sound_t s);
    case (s)
      CRASH:       return 2'd3;
      CELEBRATION: return 2'd2;
      NEXTLEVEL:   return 2'd1;
      default:     return 2'd0;
    endcase
  endfunction

  // Highest-priority sound present in a request mask (UI_PRESS if empty).
  function automatic sound_t pick_highest(logic [3:0] mask);
    if (mask[CRASH])            return CRASH;
    else if (mask[CELEBRATION]) return CELEBRATION;
    else if (mask[NEXTLEVEL])   return NEXTLEVEL;
    else                        return UI_PRESS;
  endfunction

  function automatic logic [3:0] sound_bit(sound_t s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/sound_sequencer_if.sv
// Request/tone bus between gamestate (master) and the sound sequencer (slave).
interface sound_sequencer_if #(
  parameter int NOTE_W = 8
);
  logic              playsound;
  logic [1:0]        soundselector;
  logic              mute;
  logic [NOTE_W-1:0] tone_code;
  logic              tone_en;
  logic              busy;
  logic [1:0]        active_sound;
  logic              done;

  modport master (
    output playsound, soundselector, mute,
    input  tone_code, tone_en, busy, active_sound, done
  );

  modport slave (
    input  playsound, soundselector, mute,
    output tone_code, tone_en, busy, active_sound, done
  );
endinterface

// File: rtl/sound_cue_rom.sv
// Combinational cue lookup: (sound, note index) -> note and last-note flag.
module sound_cue_rom
  import sound_pkg::*;
(
  input  sound_t           sound,
  input  logic [IDX_W-1:0] index,
  output note_t            note,
  output logic             last_note
);

  // Table lookup; last_note marks the final entry of the selected cue.
  always_comb begin
    note      = CUE_NOTES[{sound, index}];
    last_note = (index == CUE_LAST[sound]);
  end

endmodule

// File: rtl/sound_sequencer.sv
// Arbitrates game sound requests onto the single tone generator and steps
// the winning cue's notes with exact tick-based timing.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int CLK_HZ  = 25_000_000,
  parameter int TICK_HZ = 1000,
  parameter int NOTE_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  sound_sequencer_if.slave bus
);

  // CLK_HZ must be an integer multiple of TICK_HZ.
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

  seq_state_t         state_q, state_d;
  logic [3:0]         pending_q, pending_d;
  sound_t             active_q, active_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic               play_prev_q, play_prev_d;
  logic [1:0]         sel_prev_q, sel_prev_d;

  sound_t           req_sound;
  logic             capture;
  logic [3:0]       cap_mask;
  logic [3:0]       eff_pending;
  logic [3:0]       clear_mask;
  sound_t           pick;
  logic             preempt;
  logic             tick;
  logic             seg_end;
  logic             done_c;
  logic [IDX_W-1:0] rom_idx;
  note_t            rom_note;
  logic             rom_last;

  sound_cue_rom u_rom (
    .sound     (active_q),
    .index     (rom_idx),
    .note      (rom_note),
    .last_note (rom_last)
  );

  // Request edge detect and arbitration; a fresh capture is visible to the
  // picker in the same cycle so a request while idle loads next cycle.
  always_comb begin
    req_sound   = sound_t'(bus.soundselector);
    capture     = bus.playsound && (!play_prev_q || (bus.soundselector != sel_prev_q));
    cap_mask    = capture ? sound_bit(req_sound) : 4'b0000;
    eff_pending = pending_q | cap_mask;
    pick        = pick_highest(eff_pending);
    preempt     = (state_q != ST_IDLE) && (eff_pending != 4'b0000) &&
                  (prio_rank(pick) > prio_rank(active_q));
    play_prev_d = bus.playsound;
    sel_prev_d  = bus.soundselector;
  end

  // Tick and segment-end detection; during a gap the ROM looks ahead to the
  // next note so its duration is ready when the gap ends.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    seg_end = tick && (dur_q == DUR_W'(1));
    rom_idx = (state_q == ST_GAP) ? idx_q + 1'b1 : idx_q;
  end

  // Sequencer next-state: note/gap stepping, completion and preemption.
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    idx_d      = idx_q;
    presc_d    = tick ? '0 : presc_q + 1'b1;
    dur_d      = tick ? dur_q - 1'b1 : dur_q;
    clear_mask = 4'b0000;
    done_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        if (eff_pending != 4'b0000) begin
          state_d    = ST_LOAD;
          active_d   = pick;
          idx_d      = '0;
          clear_mask = sound_bit(pick);
        end
      end
      ST_LOAD: begin
        idx_d   = '0;
        presc_d = '0;
        dur_d   = rom_note.dur;
        state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (seg_end) begin
          presc_d = '0;
          if (rom_last) begin
            done_c   = 1'b1;
            active_d = UI_PRESS;
            state_d  = ST_IDLE;
          end else begin
            dur_d   = GAP_TICKS;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (seg_end) begin
          idx_d   = idx_q + 1'b1;
          presc_d = '0;
          dur_d   = rom_note.dur;
          state_d = ST_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A strictly higher-priority request drops the active cue outright.
    if (preempt) begin
      state_d    = ST_LOAD;
      active_d   = pick;
      idx_d      = '0;
      clear_mask = sound_bit(pick);
      done_c     = 1'b0;
    end
  end

  // Pending mask: a new capture of a bit that was already pending survives
  // the clear, so the second request is not lost.
  always_comb begin
    pending_d = (pending_q & cap_mask) | ((pending_q | cap_mask) & ~clear_mask);
  end

  // Output decode from the registered sequencer state.
  always_comb begin
    bus.busy         = (state_q != ST_IDLE);
    bus.tone_en      = (state_q == ST_PLAY) && !bus.mute;
    bus.tone_code    = (state_q == ST_PLAY) ? NOTE_W'(rom_note.code) : '0;
    bus.active_sound = active_q;
    bus.done         = done_c && !reset;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pending_q   <= 4'b0000;
      active_q    <= UI_PRESS;
      idx_q       <= '0;
      presc_q     <= '0;
      dur_q       <= '0;
      play_prev_q <= 1'b0;
      sel_prev_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      active_q    <= active_d;
      idx_q       <= idx_d;
      presc_q     <= presc_d;
      dur_q       <= dur_d;
      play_prev_q <= play_prev_d;
      sel_prev_q  <= sel_prev_d;
    end
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer at DIV=4: cue table vectors, corner-case
// sequences and randomized traffic against a schedule-based reference model.
module tb_sound_sequencer;

  localparam int DIV     = 4;
  localparam int GAP_CYC = 10 * DIV;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sound_sequencer_if #(.NOTE_W(8)) bus ();

  sound_sequencer #(.CLK_HZ(4000), .TICK_HZ(1000), .NOTE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int printed     = 0;

  // Cue contents written out independently of the design package.
  int cue_n    [4]    = '{1, 3, 2, 4};
  int cue_code [4][4] = '{'{'h30, 0, 0, 0}, '{'h28, 'h30, 'h38, 0},
                          '{'h50, 'h60, 0, 0}, '{'h30, 'h38, 'h40, 'h48}};
  int cue_dur  [4][4] = '{'{40, 0, 0, 0}, '{60, 60, 60, 0},
                          '{150, 150, 0, 0}, '{100, 100, 100, 100}};

  function automatic int rank(int s);
    case (s)
      2: return 3;
      3: return 2;
      1: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic void check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      if (printed < 40) begin
        printed++;
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
    end
  endfunction

  // Reference model: phase 0 idle, 1 load, 2 play; a playing cue is a queue
  // of per-cycle entries (tone code, or -1 for a silent gap cycle).
  int m_phase = 0;
  int m_active = 0;
  bit m_pend [4] = '{0, 0, 0, 0};
  int m_sched [$];
  bit m_prev_ps = 0;
  int m_prev_sel = 0;

  int s_en, s_code, s_busy, s_done, s_active;

  // One clock cycle: drive inputs, sample outputs mid-cycle, compare, advance model.
  task automatic step(input bit ps, input int sel, input bit mu, input bit rst);
    bit cap, pre;
    int best, consumed, n;
    int e_en, e_busy, e_done, e_active;
    @(posedge clk);
    #1;
    reset             = rst;
    bus.playsound     = ps;
    bus.soundselector = 2'(sel);
    bus.mute          = mu;
    @(negedge clk);
    s_en     = bus.tone_en ? 1 : 0;
    s_code   = int'(bus.tone_code);
    s_busy   = bus.busy ? 1 : 0;
    s_done   = bus.done ? 1 : 0;
    s_active = int'(bus.active_sound);

    cap  = ps && (!m_prev_ps || sel != m_prev_sel);
    best = -1;
    for (int s = 0; s < 4; s++)
      if ((m_pend[s] || (cap && sel == s)) && (best < 0 || rank(s) > rank(best))) best = s;
    pre = (m_phase != 0) && (best >= 0) && (rank(best) > rank(m_active));

    e_busy   = (m_phase != 0) ? 1 : 0;
    e_active = (m_phase != 0) ? m_active : 0;
    e_en     = (m_phase == 2 && m_sched.size() > 0 && m_sched[0] >= 0 && !mu) ? 1 : 0;
    e_done   = (m_phase == 2 && m_sched.size() == 1 && !pre && !rst) ? 1 : 0;
    check("model_busy", s_busy, e_busy);
    check("model_active_sound", s_active, e_active);
    check("model_tone_en", s_en, e_en);
    check("model_done", s_done, e_done);
    if (e_en == 1) check("model_tone_code", s_code, m_sched[0]);

    if (rst) begin
      m_phase = 0;
      m_active = 0;
      m_sched.delete();
      for (int s = 0; s < 4; s++) m_pend[s] = 0;
      m_prev_ps = 0;
      m_prev_sel = 0;
    end else begin
      consumed = -1;
      if ((m_phase == 0 && best >= 0) || pre) begin
        m_phase = 1;
        m_active = best;
        consumed = best;
        m_sched.delete();
      end else if (m_phase == 1) begin
        for (int i = 0; i < cue_n[m_active]; i++) begin
          repeat (cue_dur[m_active][i] * DIV) m_sched.push_back(cue_code[m_active][i]);
          if (i < cue_n[m_active] - 1) repeat (GAP_CYC) m_sched.push_back(-1);
        end
        m_phase = 2;
      end else if (m_phase == 2) begin
        void'(m_sched.pop_front());
        if (m_sched.size() == 0) begin
          m_phase = 0;
          m_active = 0;
        end
      end
      for (int s = 0; s < 4; s++) begin
        n = (m_pend[s] ? 1 : 0) + ((cap && sel == s) ? 1 : 0) - ((consumed == s) ? 1 : 0);
        m_pend[s] = (n > 0);
      end
      m_prev_ps = ps;
      m_prev_sel = sel;
    end
  endtask

  // Step with no request until busy drops; counts busy cycles, dones, tone cycles.
  task automatic drain(input int sel, input bit mu, output int busy_cyc, output int dones,
                       output int en_cyc, output int last_done_at);
    bit ok;
    busy_cyc = 0; dones = 0; en_cyc = 0; last_done_at = -1; ok = 0;
    for (int k = 0; k < 4000; k++) begin
      step(0, sel, mu, 0);
      if (s_busy == 0) begin
        ok = 1;
        break;
      end
      busy_cyc++;
      en_cyc += s_en;
      if (s_done == 1) begin
        dones++;
        last_done_at = busy_cyc;
      end
    end
    check("drain_timeout", ok ? 1 : 0, 1);
  endtask

  typedef struct packed {
    logic [1:0]       sel;
    logic [2:0]       n;
    logic [3:0][7:0]  code;
    logic [3:0][11:0] len;
    logic [11:0]      busy_cycles;
  } cue_vec_t;

  cue_vec_t tbl [4];

  initial begin
    int bc, dn, ec, ld, notes, on_run, off_run, cyc, dones, first_on, done_at;
    bit fin;
    bit r_ps, r_mu;
    int r_sel;

    tbl[0] = '{sel: 2'd0, n: 3'd1, code: {8'h00, 8'h00, 8'h00, 8'h30},
               len: {12'd0, 12'd0, 12'd0, 12'd160}, busy_cycles: 12'd161};
    tbl[1] = '{sel: 2'd1, n: 3'd3, code: {8'h00, 8'h38, 8'h30, 8'h28},
               len: {12'd0, 12'd240, 12'd240, 12'd240}, busy_cycles: 12'd801};
    tbl[2] = '{sel: 2'd2, n: 3'd2, code: {8'h00, 8'h00, 8'h60, 8'h50},
               len: {12'd0, 12'd0, 12'd600, 12'd600}, busy_cycles: 12'd1241};
    tbl[3] = '{sel: 2'd3, n: 3'd4, code: {8'h48, 8'h40, 8'h38, 8'h30},
               len: {12'd400, 12'd400, 12'd400, 12'd400}, busy_cycles: 12'd1721};

    reset = 1'b1;
    bus.playsound = 1'b0;
    bus.soundselector = 2'd0;
    bus.mute = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state
    step(0, 0, 0, 0);
    check("reset_busy", s_busy, 0);
    check("reset_tone_en", s_en, 0);
    check("reset_active", s_active, 0);
    check("reset_done", s_done, 0);
    $display("reset: busy=%0d tone_en=%0d active=%0d", s_busy, s_en, s_active);

    // Cue table: one single-cycle request per sound, measured note by note.
    for (int v = 0; v < 4; v++) begin
      step(1, int'(tbl[v].sel), 0, 0);
      step(0, int'(tbl[v].sel), 0, 0);
      check("load_busy", s_busy, 1);
      check("load_tone_en", s_en, 0);
      cyc = 1; notes = 0; on_run = 0; off_run = 0; dones = 0; first_on = -1;
      done_at = -1; fin = 0;
      for (int k = 0; k < 3000; k++) begin
        step(0, int'(tbl[v].sel), 0, 0);
        if (s_busy == 0) begin
          fin = 1;
          break;
        end
        cyc++;
        if (s_done == 1) begin
          dones++;
          done_at = cyc;
        end
        if (s_en == 1) begin
          if (on_run == 0) begin
            if (off_run > 0) check("gap_len", off_run, GAP_CYC);
            off_run = 0;
            if (first_on < 0) first_on = cyc;
            if (notes < 4) check("note_code", s_code, int'(tbl[v].code[notes]));
          end
          on_run++;
        end else begin
          if (on_run > 0) begin
            if (notes < 4) check("note_len", on_run, int'(tbl[v].len[notes]));
            notes++;
            on_run = 0;
          end
          off_run++;
        end
      end
      if (on_run > 0) begin
        if (notes < 4) check("note_len", on_run, int'(tbl[v].len[notes]));
        notes++;
      end
      check("cue_timeout", fin ? 1 : 0, 1);
      check("first_tone_offset", first_on, 2);
      check("note_count", notes, int'(tbl[v].n));
      check("busy_cycles", cyc, int'(tbl[v].busy_cycles));
      check("done_count", dones, 1);
      check("done_on_last_cycle", done_at, cyc);
      $display("vector %0d: sound=%0d notes=%0d busy=%0d done=%0d", v, tbl[v].sel, notes, cyc, dones);
    end

    // CELEBRATION preempted by CRASH in the middle of its second note.
    step(1, 3, 0, 0);
    repeat (541) step(0, 3, 0, 0);
    check("pre_note2_code", s_code, 'h38);
    step(1, 2, 0, 0);
    step(0, 2, 0, 0);
    check("preempt_active", s_active, 2);
    check("preempt_busy", s_busy, 1);
    check("preempt_tone_en", s_en, 0);
    drain(2, 0, bc, dn, ec, ld);
    check("preempt_crash_play", bc, 1240);
    check("preempt_done_count", dn, 1);
    $display("preempt: crash busy=%0d dones=%0d", bc, dn);

    // UI_PRESS waits for CRASH, then starts after one idle cycle.
    step(1, 2, 0, 0);
    repeat (100) step(0, 2, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("no_preempt_active", s_active, 2);
    drain(0, 0, bc, dn, ec, ld);
    check("crash_done_before_ui", dn, 1);
    step(0, 0, 0, 0);
    check("ui_load_busy", s_busy, 1);
    check("ui_load_active", s_active, 0);
    drain(0, 0, bc, dn, ec, ld);
    check("ui_after_crash_tone", ec, 160);
    check("ui_after_crash_done", dn, 1);
    $display("queued: ui tone=%0d dones=%0d", ec, dn);

    // Held request level produces exactly one cue.
    bc = 0; dn = 0;
    for (int k = 0; k < 500; k++) begin
      step(1, 1, 0, 0);
      bc += s_busy;
      dn += s_done;
    end
    begin
      int b2, d2, e2, l2;
      drain(1, 0, b2, d2, e2, l2);
      bc += b2;
      dn += d2;
    end
    check("held_busy_cycles", bc, 801);
    check("held_done_count", dn, 1);
    bc = 0;
    repeat (50) begin
      step(0, 1, 0, 0);
      bc += s_busy;
    end
    check("held_no_replay", bc, 0);
    $display("held: busy=%0d dones=%0d", 801, dn);

    // Reset mid-cue with several requests pending.
    step(1, 3, 0, 0);
    repeat (200) step(0, 3, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 3, 0, 0);
    step(0, 3, 0, 0);
    step(0, 3, 0, 1);
    step(0, 3, 0, 0);
    check("rst_mid_busy", s_busy, 0);
    check("rst_mid_tone_en", s_en, 0);
    check("rst_mid_active", s_active, 0);
    check("rst_mid_done", s_done, 0);
    bc = 0;
    repeat (100) begin
      step(0, 3, 0, 0);
      bc += s_busy;
    end
    check("rst_no_replay", bc, 0);
    $display("reset mid-cue: busy after=%0d", bc);

    // Muted cue: no tone, completion timing unchanged.
    step(1, 0, 1, 0);
    drain(0, 1, bc, dn, ec, ld);
    check("mute_busy_cycles", bc, 161);
    check("mute_tone_cycles", ec, 0);
    check("mute_done_at", ld, 161);
    $display("mute: busy=%0d tone=%0d done_at=%0d", bc, ec, ld);

    // Random traffic, every cycle checked against the model.
    r_ps = 0; r_sel = 0; r_mu = 0;
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 39) == 0) r_ps = !r_ps;
      if ($urandom_range(0, 29) == 0) r_sel = int'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) r_mu = !r_mu;
      step(r_ps, r_sel, r_mu, $urandom_range(0, 2999) == 0);
    end
    drain(r_sel, 0, bc, dn, ec, ld);
    $display("random: 6000 cycles applied");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
